// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO controller: register address map and bus widths.
package gpio_pkg;

    localparam int ADDR_W = 3;

    typedef enum logic [ADDR_W-1:0] {
        GPIO_IN      = 3'd0,
        GPIO_OUT     = 3'd1,
        GPIO_DIR     = 3'd2,
        GPIO_IRQ_EN  = 3'd3,
        GPIO_RISE_EN = 3'd4,
        GPIO_FALL_EN = 3'd5,
        GPIO_PEND    = 3'd6,
        GPIO_TOGGLE  = 3'd7
    } gpio_addr_e;

endpackage

// File: rtl/gpio_sync.sv
// Per-pin multi-flop synchroniser for asynchronous GPIO inputs, clocked on the falling edge.
module gpio_sync #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pins,
    output logic [WIDTH-1:0] synced
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [SYNC_STAGES-1:0] chain_reg;

            always_ff @(negedge clk or negedge rst) begin
                if (!rst) begin
                    chain_reg <= '0;
                end else begin
                    chain_reg <= {chain_reg[SYNC_STAGES-2:0], pins[gi]};
                end
            end

            assign synced[gi] = chain_reg[SYNC_STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO controller: direction/output registers, atomic toggle,
// synchronised inputs with rising/falling edge capture and a maskable irq.
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              write,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata,
    input  logic [WIDTH-1:0]  gpio_in,
    output logic [WIDTH-1:0]  gpio_out,
    output logic [WIDTH-1:0]  gpio_oe,
    output logic              irq
);

    logic [WIDTH-1:0] sync_val;

    logic [WIDTH-1:0] out_reg,     out_next;
    logic [WIDTH-1:0] dir_reg,     dir_next;
    logic [WIDTH-1:0] irq_en_reg,  irq_en_next;
    logic [WIDTH-1:0] rise_en_reg, rise_en_next;
    logic [WIDTH-1:0] fall_en_reg, fall_en_next;
    logic [WIDTH-1:0] pend_reg,    pend_next;
    logic [WIDTH-1:0] prev_reg;
    logic [WIDTH-1:0] pend_clr;
    logic [WIDTH-1:0] edge_hit;

    gpio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .pins   (gpio_in),
        .synced (sync_val)
    );

    // Output-driven pins are still sampled, so loopback self-test can see its own edges.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_edge
            assign edge_hit[gi] = (sync_val[gi] & ~prev_reg[gi] & rise_en_reg[gi])
                                | (~sync_val[gi] & prev_reg[gi] & fall_en_reg[gi]);
        end
    endgenerate

    always_comb begin
        out_next     = out_reg;
        dir_next     = dir_reg;
        irq_en_next  = irq_en_reg;
        rise_en_next = rise_en_reg;
        fall_en_next = fall_en_reg;
        pend_clr     = '0;
        if (write) begin
            case (gpio_addr_e'(addr))
                GPIO_OUT:     out_next     = wdata;
                GPIO_DIR:     dir_next     = wdata;
                GPIO_IRQ_EN:  irq_en_next  = wdata;
                GPIO_RISE_EN: rise_en_next = wdata;
                GPIO_FALL_EN: fall_en_next = wdata;
                GPIO_PEND:    pend_clr     = wdata;
                GPIO_TOGGLE:  out_next     = out_reg ^ wdata;
                default:      ;
            endcase
        end
        // New edges are OR-ed in after the clear so a simultaneous set wins.
        pend_next = (pend_reg & ~pend_clr) | edge_hit;
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            out_reg     <= '0;
            dir_reg     <= '0;
            irq_en_reg  <= '0;
            rise_en_reg <= '0;
            fall_en_reg <= '0;
            pend_reg    <= '0;
            prev_reg    <= '0;
        end else begin
            out_reg     <= out_next;
            dir_reg     <= dir_next;
            irq_en_reg  <= irq_en_next;
            rise_en_reg <= rise_en_next;
            fall_en_reg <= fall_en_next;
            pend_reg    <= pend_next;
            prev_reg    <= sync_val;
        end
    end

    always_comb begin
        rdata = '0;
        case (gpio_addr_e'(addr))
            GPIO_IN:      rdata = sync_val;
            GPIO_OUT:     rdata = out_reg;
            GPIO_DIR:     rdata = dir_reg;
            GPIO_IRQ_EN:  rdata = irq_en_reg;
            GPIO_RISE_EN: rdata = rise_en_reg;
            GPIO_FALL_EN: rdata = fall_en_reg;
            GPIO_PEND:    rdata = pend_reg;
            GPIO_TOGGLE:  rdata = '0;
            default:      rdata = '0;
        endcase
    end

    assign gpio_out = out_reg;
    assign gpio_oe  = dir_reg;
    assign irq      = |(pend_reg & irq_en_reg);

endmodule

// File: tb/tb_gpio_ctrl.sv
// Scoreboard bench for gpio_ctrl: two instances (8 pins/2 stages and 32 pins/3 stages) share one bus.
module tb_gpio_ctrl;
    import gpio_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  addr = '0;
    logic        write = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] gpio_in = '0;

    logic [7:0]  rdata_a, out_a, oe_a;
    logic        irq_a;
    logic [31:0] rdata_b, out_b, oe_b;
    logic        irq_b;

    always #5 clk = ~clk;

    gpio_ctrl #(.WIDTH(8), .SYNC_STAGES(2)) u_a (
        .clk(clk), .rst(rst), .addr(addr), .write(write), .wdata(wdata[7:0]),
        .rdata(rdata_a), .gpio_in(gpio_in[7:0]), .gpio_out(out_a), .gpio_oe(oe_a), .irq(irq_a)
    );

    gpio_ctrl #(.WIDTH(32), .SYNC_STAGES(3)) u_b (
        .clk(clk), .rst(rst), .addr(addr), .write(write), .wdata(wdata),
        .rdata(rdata_b), .gpio_in(gpio_in), .gpio_out(out_b), .gpio_oe(oe_b), .irq(irq_b)
    );

    // Reference model: registers as plain words, inputs as a history of samples per falling edge.
    int          stages [2] = '{2, 3};
    logic [31:0] mask   [2] = '{32'h0000_00FF, 32'hFFFF_FFFF};
    logic [31:0] m_out [2], m_dir [2], m_ien [2], m_ren [2], m_fen [2], m_pend [2];
    logic [31:0] hist  [2][8];

    typedef struct {
        int          cfg;
        string       name;
        bit [3:0]    sel;
        logic [31:0] rd;
        logic [31:0] go;
        logic [31:0] oe;
        logic        irq;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_out[c] = '0; m_dir[c] = '0; m_ien[c] = '0;
            m_ren[c] = '0; m_fen[c] = '0; m_pend[c] = '0;
            for (int j = 0; j < 8; j++) hist[c][j] = '0;
        end
    endtask

    task automatic model_step(input logic [2:0] a, input logic w, input logic [31:0] d, input logic [31:0] g);
        for (int c = 0; c < 2; c++) begin
            logic [31:0] cur, pri, hits, dm;
            for (int j = 7; j > 0; j--) hist[c][j] = hist[c][j-1];
            hist[c][0] = g & mask[c];
            cur  = hist[c][stages[c]];
            pri  = hist[c][stages[c] + 1];
            hits = (cur & ~pri & m_ren[c]) | (~cur & pri & m_fen[c]);
            dm   = d & mask[c];
            if (w) begin
                case (a)
                    3'd1: m_out[c]  = dm;
                    3'd2: m_dir[c]  = dm;
                    3'd3: m_ien[c]  = dm;
                    3'd4: m_ren[c]  = dm;
                    3'd5: m_fen[c]  = dm;
                    3'd6: m_pend[c] = m_pend[c] & ~dm;
                    3'd7: m_out[c]  = m_out[c] ^ dm;
                    default: ;
                endcase
            end
            m_pend[c] = m_pend[c] | hits;
        end
    endtask

    function automatic logic [31:0] model_rd(input int c, input logic [2:0] a);
        case (a)
            3'd0: return hist[c][stages[c] - 1];
            3'd1: return m_out[c];
            3'd2: return m_dir[c];
            3'd3: return m_ien[c];
            3'd4: return m_ren[c];
            3'd5: return m_fen[c];
            3'd6: return m_pend[c];
            default: return 32'h0;
        endcase
    endfunction

    task automatic push_model(input string name, input logic [2:0] a);
        for (int c = 0; c < 2; c++) begin
            exp_t e;
            e.cfg = c; e.name = name; e.sel = 4'hF;
            e.rd  = model_rd(c, a);
            e.go  = m_out[c];
            e.oe  = m_dir[c];
            e.irq = |(m_pend[c] & m_ien[c]);
            sb.push_back(e);
        end
    endtask

    // sel bits: 0 rdata, 1 gpio_out, 2 gpio_oe, 3 irq
    task automatic lit(input string name, input int c, input bit [3:0] sel,
                       input logic [31:0] rd, input logic [31:0] go, input logic [31:0] oe, input logic irq_v);
        exp_t e;
        e.cfg = c; e.name = name; e.sel = sel;
        e.rd = rd; e.go = go; e.oe = oe; e.irq = irq_v;
        sb.push_back(e);
    endtask

    task automatic cyc(input logic [2:0] a, input logic w, input logic [31:0] d, input logic [31:0] g,
                       input string name);
        @(posedge clk);
        addr = a; write = w; wdata = d; gpio_in = g;
        push_model(name, a);
        model_step(a, w, d, g);
    endtask

    task automatic do_reset(input string name);
        logic [31:0] g;
        @(posedge clk);
        addr = 3'($urandom); write = 1'b1; wdata = $urandom; gpio_in = $urandom;
        #1 rst = 1'b0;
        model_reset();
        for (int a = 0; a < 8; a++) begin
            if (a > 0) begin
                @(posedge clk);
                write = 1'($urandom); wdata = $urandom; gpio_in = $urandom;
            end
            addr = 3'(a);
            for (int c = 0; c < 2; c++) lit(name, c, 4'hF, 32'h0, 32'h0, 32'h0, 1'b0);
        end
        @(posedge clk);
        g = $urandom;
        #1;
        write = 1'b0; wdata = '0; gpio_in = g;
        rst = 1'b1;
        model_step(addr, 1'b0, 32'h0, g);
    endtask

    // Monitor: compares every queued expectation against the DUT pins mid-cycle.
    initial begin
        forever begin
            exp_t e;
            logic [31:0] ard, ago, aoe;
            logic airq;
            @(posedge clk);
            #3;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.cfg == 0) begin
                    ard = {24'h0, rdata_a}; ago = {24'h0, out_a}; aoe = {24'h0, oe_a}; airq = irq_a;
                end else begin
                    ard = rdata_b; ago = out_b; aoe = oe_b; airq = irq_b;
                end
                if (e.sel[0]) begin
                    vectors++;
                    if (ard !== e.rd) begin
                        miscompares++;
                        $display("FAIL %s cfg%0d rdata addr=%0d got=%h want=%h", e.name, e.cfg, addr, ard, e.rd);
                    end
                end
                if (e.sel[1]) begin
                    vectors++;
                    if (ago !== e.go) begin
                        miscompares++;
                        $display("FAIL %s cfg%0d gpio_out got=%h want=%h", e.name, e.cfg, ago, e.go);
                    end
                end
                if (e.sel[2]) begin
                    vectors++;
                    if (aoe !== e.oe) begin
                        miscompares++;
                        $display("FAIL %s cfg%0d gpio_oe got=%h want=%h", e.name, e.cfg, aoe, e.oe);
                    end
                end
                if (e.sel[3]) begin
                    vectors++;
                    if (airq !== e.irq) begin
                        miscompares++;
                        $display("FAIL %s cfg%0d irq got=%b want=%b", e.name, e.cfg, airq, e.irq);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] g;
        model_reset();
        do_reset("reset_init");

        // Output register and atomic toggle
        cyc(GPIO_OUT, 1'b1, 32'hA5, 32'h0, "out_wr");
        cyc(GPIO_TOGGLE, 1'b1, 32'h0F, 32'h0, "toggle_wr");
        cyc(GPIO_DIR, 1'b1, 32'hF0, 32'h0, "dir_wr");
        for (int c = 0; c < 2; c++) lit("toggle_out", c, 4'b0010, 32'h0, 32'hAA, 32'h0, 1'b0);
        cyc(GPIO_TOGGLE, 1'b0, 32'h0, 32'h0, "rd_toggle");
        for (int c = 0; c < 2; c++) lit("dir_oe_rd7", c, 4'b0101, 32'h0, 32'h0, 32'hF0, 1'b0);

        // Input synchroniser latency
        repeat (4) cyc(GPIO_IN, 1'b0, 32'h0, 32'h0, "idle");
        cyc(GPIO_IN, 1'b0, 32'h0, 32'h81, "sync_n");
        cyc(GPIO_IN, 1'b0, 32'h0, 32'h81, "sync_n0");
        for (int c = 0; c < 2; c++) lit("sync_after_n", c, 4'b0001, 32'h0, 32'h0, 32'h0, 1'b0);
        cyc(GPIO_IN, 1'b0, 32'h0, 32'h81, "sync_n1");
        lit("sync_after_n1", 0, 4'b0001, 32'h81, 32'h0, 32'h0, 1'b0);
        lit("sync_after_n1", 1, 4'b0001, 32'h00, 32'h0, 32'h0, 1'b0);
        cyc(GPIO_IN, 1'b0, 32'h0, 32'h81, "sync_n2");
        for (int c = 0; c < 2; c++) lit("sync_after_n2", c, 4'b0001, 32'h81, 32'h0, 32'h0, 1'b0);

        // Edge capture and irq
        repeat (5) cyc(GPIO_IN, 1'b0, 32'h0, 32'h0, "settle");
        cyc(GPIO_PEND, 1'b1, 32'hFFFF_FFFF, 32'h0, "pend_clr");
        cyc(GPIO_RISE_EN, 1'b1, 32'h01, 32'h0, "rise_en_wr");
        cyc(GPIO_FALL_EN, 1'b1, 32'h80, 32'h0, "fall_en_wr");
        cyc(GPIO_IRQ_EN, 1'b1, 32'h81, 32'h0, "irq_en_wr");
        cyc(GPIO_PEND, 1'b0, 32'h0, 32'h81, "rise_n");
        cyc(GPIO_PEND, 1'b0, 32'h0, 32'h81, "rise_n0");
        cyc(GPIO_PEND, 1'b0, 32'h0, 32'h81, "rise_n1");
        for (int c = 0; c < 2; c++) lit("pend_after_n1", c, 4'b1001, 32'h0, 32'h0, 32'h0, 1'b0);
        cyc(GPIO_PEND, 1'b0, 32'h0, 32'h81, "rise_n2");
        lit("pend_after_n2", 0, 4'b1001, 32'h01, 32'h0, 32'h0, 1'b1);
        lit("pend_after_n2", 1, 4'b1001, 32'h00, 32'h0, 32'h0, 1'b0);
        cyc(GPIO_PEND, 1'b0, 32'h0, 32'h81, "rise_n3");
        for (int c = 0; c < 2; c++) lit("pend_after_n3", c, 4'b1001, 32'h01, 32'h0, 32'h0, 1'b1);
        cyc(GPIO_PEND, 1'b1, 32'h01, 32'h81, "w1c");
        cyc(GPIO_PEND, 1'b0, 32'h0, 32'h81, "w1c_chk");
        for (int c = 0; c < 2; c++) lit("w1c_clears", c, 4'b1001, 32'h0, 32'h0, 32'h0, 1'b0);
        cyc(GPIO_PEND, 1'b1, 32'h01, 32'h81, "w1c_idle");
        cyc(GPIO_PEND, 1'b0, 32'h0, 32'h0, "fall_n");
        repeat (4) cyc(GPIO_PEND, 1'b0, 32'h0, 32'h0, "fall_wait");
        cyc(GPIO_PEND, 1'b0, 32'h0, 32'h0, "fall_chk");
        for (int c = 0; c < 2; c++) lit("fall_pend", c, 4'b1001, 32'h80, 32'h0, 32'h0, 1'b1);
        cyc(GPIO_IRQ_EN, 1'b1, 32'h0, 32'h0, "ien_off");
        cyc(GPIO_PEND, 1'b0, 32'h0, 32'h0, "ien_chk");
        for (int c = 0; c < 2; c++) lit("masked_irq", c, 4'b1001, 32'h80, 32'h0, 32'h0, 1'b0);

        // Set-wins collision, timed to hit each configuration's capture edge in turn
        for (int k = 2; k <= 3; k++) begin
            cyc(GPIO_IRQ_EN, 1'b1, 32'h01, 32'h0, "coll_ien");
            cyc(GPIO_PEND, 1'b1, 32'hFFFF_FFFF, 32'h0, "coll_clr");
            repeat (5) cyc(GPIO_PEND, 1'b0, 32'h0, 32'h1, "coll_pre");
            repeat (5) cyc(GPIO_PEND, 1'b0, 32'h0, 32'h0, "coll_low");
            cyc(GPIO_PEND, 1'b0, 32'h0, 32'h1, "coll_n");
            repeat (k - 1) cyc(GPIO_PEND, 1'b0, 32'h0, 32'h1, "coll_wait");
            cyc(GPIO_PEND, 1'b1, 32'h01, 32'h1, "coll_w1c");
            cyc(GPIO_PEND, 1'b0, 32'h0, 32'h1, "coll_chk");
            for (int c = 0; c < 2; c++) begin
                if (stages[c] == k) lit("set_wins", c, 4'b1001, 32'h1, 32'h0, 32'h0, 1'b1);
                else                lit("clr_no_edge", c, 4'b1001, 32'h0, 32'h0, 32'h0, 1'b0);
            end
        end

        // Randomised traffic, mid-run reset, more traffic
        for (int i = 0; i < 400; i++) begin
            g = ($urandom_range(0, 3) == 0) ? $urandom : gpio_in;
            cyc(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom, g, "rand");
        end
        do_reset("reset_mid");
        for (int i = 0; i < 200; i++) begin
            g = ($urandom_range(0, 2) == 0) ? $urandom : gpio_in;
            cyc(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom, g, "rand2");
        end

        for (int t = 0; t < 20 && sb.size() > 0; t++) @(negedge clk);
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain %0d expectations left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
